// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a req/ack data-memory access, little-endian
// byte/half/word alignment by opcode, and the MEM/WB pipeline register.
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   RegWriteM, MemtoRegM, MemWriteM EX/MEM control bits
//   alu_outM, r3_addrM, opM         EX/MEM ALU result / address, destination register, opcode
//   r2_doutM                        EX/MEM store data
//   dmem_req/we/addr/wdata/be       registered data-memory request (held stable while waiting)
//   dmem_rdata, dmem_ack            data-memory response (ack is a single-cycle pulse)
//   stall_mem                       combinational freeze of PC, IF/ID, ID/EX and EX/MEM
//   bus_err                         single-cycle pulse on access timeout (or misalignment trap)
//   RegWriteW, MemtoRegW, alu_outW, read_dataW, r3_addrW   MEM/WB register
//
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses
// instead of silently ignoring the low address bits.
module mem_stage #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [31:0] alu_outM,
  input  logic [4:0]  r3_addrM,
  input  logic [5:0]  opM,
  input  logic [31:0] r2_doutM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_mem,
  output logic        bus_err,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] alu_outW,
  output logic [31:0] read_dataW,
  output logic [4:0]  r3_addrW
);
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24,
                         OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic req_q, req_d, we_q, we_d, bus_err_q, bus_err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0] be_q, be_d;
  logic rw_q, rw_d, m2r_q, m2r_d;
  logic [31:0] alu_q, alu_d, rd_q, rd_d;
  logic [4:0] r3_q, r3_d;
  logic [1:0] a;
  logic mem_op, misalign, timeout, stall, bubble;
  logic [31:0] st_wdata, ld_data, lane;
  logic [3:0] st_be;
  logic [15:0] half;
  assign a      = alu_outM[1:0];
  assign mem_op = MemtoRegM | MemWriteM;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = ((opM == OP_LH || opM == OP_LHU || opM == OP_SH) && a[0]) ||
                    ((opM == OP_LW || opM == OP_SW) && a != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  // Abort on the TIMEOUT-th consecutive WAIT cycle without ack; 0 disables it.
  assign timeout  = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign st_wdata = opM == OP_SB ? {4{r2_doutM[7:0]}} :
                    opM == OP_SH ? {2{r2_doutM[15:0]}} : r2_doutM;
  assign st_be    = opM == OP_SB ? 4'b0001 << a :
                    opM == OP_SH ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign lane     = dmem_rdata >> {a, 3'b000};
  assign half     = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  assign ld_data  = opM == OP_LB  ? {{24{lane[7]}}, lane[7:0]} :
                    opM == OP_LBU ? {24'b0, lane[7:0]} :
                    opM == OP_LH  ? {{16{half[15]}}, half} :
                    opM == OP_LHU ? {16'b0, half} : dmem_rdata;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    bus_err_d = 1'b0;
    stall     = 1'b0;
    bubble    = 1'b0;
    rd_d      = 32'b0;
    if (state_q == IDLE) begin
      if (mem_op && misalign) begin
        bus_err_d = 1'b1;
        bubble    = 1'b1;
      end else if (mem_op) begin
        stall   = 1'b1;
        bubble  = 1'b1;
        req_d   = 1'b1;
        we_d    = MemWriteM;
        addr_d  = {alu_outM[31:2], 2'b00};
        wdata_d = MemWriteM ? st_wdata : 32'b0;
        be_d    = MemWriteM ? st_be : 4'b1111;
        cnt_d   = '0;
        state_d = WAIT;
      end
    end else if (dmem_ack) begin
      req_d   = 1'b0;
      rd_d    = ld_data;
      state_d = IDLE;
    end else if (timeout) begin
      req_d     = 1'b0;
      bus_err_d = 1'b1;
      bubble    = 1'b1;
      state_d   = IDLE;
    end else begin
      stall  = 1'b1;
      bubble = 1'b1;
      cnt_d  = cnt_q + 1'b1;
    end
    rw_d  = bubble ? 1'b0 : RegWriteM;
    m2r_d = bubble ? 1'b0 : MemtoRegM;
    alu_d = bubble ? 32'b0 : alu_outM;
    r3_d  = bubble ? 5'b0 : r3_addrM;
    rd_d  = bubble ? 32'b0 : rd_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'b0;
      wdata_q   <= 32'b0;
      be_q      <= 4'b0;
      bus_err_q <= 1'b0;
      rw_q      <= 1'b0;
      m2r_q     <= 1'b0;
      alu_q     <= 32'b0;
      rd_q      <= 32'b0;
      r3_q      <= 5'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      bus_err_q <= bus_err_d;
      rw_q      <= rw_d;
      m2r_q     <= m2r_d;
      alu_q     <= alu_d;
      rd_q      <= rd_d;
      r3_q      <= r3_d;
    end
  end
  // Gated by rst_n so the pipeline is released the moment reset asserts.
  assign stall_mem  = rst_n & stall;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;
  assign bus_err    = bus_err_q;
  assign RegWriteW  = rw_q;
  assign MemtoRegW  = m2r_q;
  assign alu_outW   = alu_q;
  assign read_dataW = rd_q;
  assign r3_addrW   = r3_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage
module tb_mem_stage;
  logic clk = 1'b0, rst_n;
  logic RegWriteM, MemtoRegM, MemWriteM;
  logic [31:0] alu_outM, r2_doutM, dmem_addr, dmem_wdata, dmem_rdata, alu_outW, read_dataW;
  logic [4:0] r3_addrM, r3_addrW;
  logic [5:0] opM;
  logic dmem_req, dmem_we, dmem_ack, stall_mem, bus_err, RegWriteW, MemtoRegW;
  logic [3:0] dmem_be;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mem_stage #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .alu_outM(alu_outM), .r3_addrM(r3_addrM), .opM(opM), .r2_doutM(r2_doutM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall_mem(stall_mem),
    .bus_err(bus_err), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .alu_outW(alu_outW),
    .read_dataW(read_dataW), .r3_addrW(r3_addrW)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_m(input logic rw, input logic m2r, input logic mw, input logic [5:0] op,
                       input logic [31:0] addr, input logic [31:0] data, input logic [4:0] r3);
    RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw; opM = op;
    alu_outM = addr; r2_doutM = data; r3_addrM = r3;
  endtask
  task automatic nop;
    set_m(1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 5'd0);
  endtask
  task automatic do_load(input string tag, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] rd, input logic [31:0] exp);
    set_m(1'b1, 1'b1, 1'b0, op, addr, 32'h0, 5'd7);
    #1 chk({tag, "_idle_stall"}, stall_mem, 1);
    tick;
    chk({tag, "_req"}, dmem_req, 1);
    chk({tag, "_we"}, dmem_we, 0);
    chk({tag, "_be"}, dmem_be, 4'hF);
    chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
    dmem_ack = 1'b1; dmem_rdata = rd;
    #1 chk({tag, "_ack_stall"}, stall_mem, 0);
    tick;
    dmem_ack = 1'b0;
    chk({tag, "_data"}, read_dataW, exp);
    chk({tag, "_regwrite"}, RegWriteW, 1);
    chk({tag, "_memtoreg"}, MemtoRegW, 1);
    chk({tag, "_r3"}, r3_addrW, 7);
    chk({tag, "_req_drop"}, dmem_req, 0);
    nop;
  endtask
  task automatic do_store(input string tag, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_wdata, input logic [3:0] exp_be);
    set_m(1'b0, 1'b0, 1'b1, op, addr, data, 5'd0);
    tick;
    chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
    chk({tag, "_be"}, dmem_be, exp_be);
    chk({tag, "_we"}, dmem_we, 1);
    dmem_ack = 1'b1;
    tick;
    dmem_ack = 1'b0;
    chk({tag, "_req_drop"}, dmem_req, 0);
    nop;
  endtask
  initial begin
    rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    nop;
    tick; tick;
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_regwrite", RegWriteW, 0);
    chk("rst_alu_outW", alu_outW, 0);
    chk("rst_stall", stall_mem, 0);
    rst_n = 1'b1;
    // ALU op passes through; stray ack in IDLE is ignored
    set_m(1'b1, 1'b0, 1'b0, 6'h00, 32'h1234, 32'h0, 5'd5);
    dmem_ack = 1'b1;
    #1 chk("alu_stall", stall_mem, 0);
    tick;
    dmem_ack = 1'b0;
    chk("alu_regwrite", RegWriteW, 1);
    chk("alu_outW", alu_outW, 32'h1234);
    chk("alu_r3", r3_addrW, 5);
    chk("alu_read_data", read_dataW, 0);
    chk("alu_no_req", dmem_req, 0);
    // sb 0x103, ack on 4th WAIT cycle (coincides with timeout count: ack wins)
    set_m(1'b0, 1'b0, 1'b1, 6'h28, 32'h103, 32'hAB, 5'd0);
    #1 chk("sb_idle_stall", stall_mem, 1);
    tick;
    chk("sb_req", dmem_req, 1);
    chk("sb_addr", dmem_addr, 32'h100);
    chk("sb_be", dmem_be, 4'b1000);
    chk("sb_wdata", dmem_wdata, 32'hABABABAB);
    chk("sb_bubble", RegWriteW, 0);
    for (int i = 0; i < 3; i++) begin
      chk("sb_wait_stall", stall_mem, 1);
      chk("sb_wait_req", dmem_req, 1);
      tick;
    end
    chk("sb_addr_held", dmem_addr, 32'h100);
    chk("sb_be_held", dmem_be, 4'b1000);
    chk("sb_wdata_held", dmem_wdata, 32'hABABABAB);
    dmem_ack = 1'b1;
    #1 chk("sb_ack_stall", stall_mem, 0);
    tick;
    dmem_ack = 1'b0;
    chk("sb_req_drop", dmem_req, 0);
    chk("sb_ack_wins", bus_err, 0);
    nop;
    do_load("lb", 6'h20, 32'h102, 32'h0080FF00, 32'hFFFFFF80);
    do_load("lbu", 6'h24, 32'h102, 32'h0080FF00, 32'h00000080);
    do_load("lb_lane1", 6'h20, 32'h101, 32'h0080FF00, 32'hFFFFFFFF);
    do_load("lh", 6'h21, 32'h102, 32'h80010000, 32'hFFFF8001);
    do_load("lhu", 6'h25, 32'h102, 32'h80010000, 32'h00008001);
    do_load("lw", 6'h23, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
    do_store("sh_hi", 6'h29, 32'h102, 32'h1234ABCD, 32'hABCDABCD, 4'b1100);
    do_store("sw", 6'h2B, 32'h204, 32'h1234ABCD, 32'h1234ABCD, 4'b1111);
    do_store("sb_lane0", 6'h28, 32'h200, 32'h000000C3, 32'hC3C3C3C3, 4'b0001);
    // timeout: no ack for 4 WAIT cycles
    set_m(1'b1, 1'b1, 1'b0, 6'h23, 32'h200, 32'h0, 5'd9);
    #1 chk("to_idle_stall", stall_mem, 1);
    tick;
    for (int i = 0; i < 3; i++) begin
      chk("to_wait_stall", stall_mem, 1);
      tick;
    end
    chk("to_release_stall", stall_mem, 0);
    chk("to_req_still", dmem_req, 1);
    chk("to_no_err_yet", bus_err, 0);
    tick;
    chk("to_bus_err", bus_err, 1);
    chk("to_req_drop", dmem_req, 0);
    chk("to_bubble", RegWriteW, 0);
    nop;
    tick;
    chk("to_err_pulse", bus_err, 0);
    // reset during WAIT cycle 2
    set_m(1'b0, 1'b0, 1'b1, 6'h2B, 32'h300, 32'h55, 5'd0);
    tick; tick;
    chk("rm_req_before", dmem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rm_req", dmem_req, 0);
    chk("rm_stall", stall_mem, 0);
    chk("rm_regwrite", RegWriteW, 0);
    chk("rm_alu_outW", alu_outW, 0);
    #3 rst_n = 1'b1;
    #1;
    chk("rm_idle_stall", stall_mem, 1);
    chk("rm_idle_req", dmem_req, 0);
    tick;
    chk("rm_reissue_req", dmem_req, 1);
    chk("rm_reissue_be", dmem_be, 4'hF);
    chk("rm_reissue_wdata", dmem_wdata, 32'h55);
    dmem_ack = 1'b1;
    tick;
    dmem_ack = 1'b0;
    nop;
    chk("rm_done_req", dmem_req, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    set_m(1'b1, 1'b1, 1'b0, 6'h23, 32'h101, 32'h0, 5'd3);
    #1 chk("mis_stall", stall_mem, 0);
    tick;
    chk("mis_bus_err", bus_err, 1);
    chk("mis_req", dmem_req, 0);
    chk("mis_bubble", RegWriteW, 0);
    nop;
    tick;
    chk("mis_err_pulse", bus_err, 0);
    chk("mis_req_never", dmem_req, 0);
`else
    do_load("lw_unaligned", 6'h23, 32'h101, 32'hCAFEF00D, 32'hCAFEF00D);
    chk("lw_unaligned_no_err", bus_err, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
